fc_par_layer: RTL and testbench

FC_PAR_LAYER -- requirements
Module: fc_par_layer

---
 rtl/fc_pkg.sv | 32 +++
 rtl/fc_mac_lane.sv | 86 ++++++++
 rtl/fc_par_layer.sv | 204 ++++++++++++++++++++
 tb/tb_fc_par_layer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// -----------------------------------------------------------------------------
// fc_pkg
// Shared types and width helpers for the parallel fully-connected layer.
//   fc_state_t      : control FSM states (load x, multiply-accumulate, drain)
//   cnt_width()     : counter/index width with a floor of one bit
//   acc_width()     : lane accumulator width, wide enough that N full-scale
//                     products cannot overflow
//   addr_width()    : weight ROM address width for M/P row groups of N words
// -----------------------------------------------------------------------------
package fc_pkg;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } fc_state_t;

  // Bits needed to index v items; never less than one bit.
  function automatic int cnt_width(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  // A T x T signed product needs 2T bits; summing N of them adds clog2(N).
  function automatic int acc_width(input int t, input int n);
    return (2 * t) + $clog2(n);
  endfunction

  function automatic int addr_width(input int m, input int p, input int n);
    return cnt_width((m / p) * n);
  endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// -----------------------------------------------------------------------------
// fc_mac_lane
// One MAC lane: signed multiply, accumulate over N columns, then saturate to
// T bits (and optionally clamp negatives to zero) into a held result register.
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   clr        : clear the accumulator (start of a row group)
//   en         : accumulate w*x this cycle
//   cap        : capture saturated (acc + w*x) into the result register
//   w, x       : signed weight and input element
//   res        : held saturated result
// -----------------------------------------------------------------------------
module fc_mac_lane
  import fc_pkg::*;
#(
  parameter int N    = 8,
  parameter int T    = 16,
  parameter int RELU = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                en,
  input  logic                cap,
  input  logic signed [T-1:0] w,
  input  logic signed [T-1:0] x,
  output logic signed [T-1:0] res
);

  localparam int ACC_W = acc_width(T, N);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W - T + 1){1'b0}}, {(T - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W - T + 1){1'b1}}, {(T - 1){1'b0}}};

  logic signed [2*T-1:0]   prod_s;
  logic signed [ACC_W-1:0] acc_sum_s;
  logic signed [ACC_W-1:0] acc_r;
  logic signed [T-1:0]     res_r;

  // Clamp the wide sum into T bits, then apply the optional ReLU.
  function automatic logic signed [T-1:0] sat_relu(input logic signed [ACC_W-1:0] v);
    logic signed [T-1:0] r;
    if (v > SAT_MAX) begin
      r = SAT_MAX[T-1:0];
    end else if (v < SAT_MIN) begin
      r = SAT_MIN[T-1:0];
    end else begin
      r = T'(v);
    end
    if ((RELU != 0) && r[T-1]) begin
      r = '0;
    end else begin
      r = r;
    end
    return r;
  endfunction

  // Product and running sum; cap uses the sum so the final column is included.
  always_comb begin
    prod_s    = w * x;
    acc_sum_s = acc_r + ACC_W'(prod_s);
  end

  // Accumulator and held result register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r <= '0;
      res_r <= '0;
    end else begin
      if (clr) begin
        acc_r <= '0;
      end else if (en) begin
        acc_r <= acc_sum_s;
      end else begin
        acc_r <= acc_r;
      end
      if (cap) begin
        res_r <= sat_relu(acc_sum_s);
      end else begin
        res_r <= res_r;
      end
    end
  end

  assign res = res_r;

endmodule

// File: rtl/fc_par_layer.sv
// -----------------------------------------------------------------------------
// fc_par_layer
// Fully-connected layer y = sat(W*x) with P parallel MAC lanes. An N-word x
// vector is loaded, then each group of P rows is accumulated over N columns
// and streamed out lane by lane.
// Ports:
//   clk, reset                 : clock, asynchronous active-low reset
//   input_valid/ready/data     : x stream, x[0] first
//   output_valid/ready/data    : y stream, y[0] first
//   addr_w                     : weight ROM address g*N + k
//   w_data                     : ROM word (1-cycle read), lane p in [p*T +: T]
// -----------------------------------------------------------------------------
module fc_par_layer
  import fc_pkg::*;
#(
  parameter int M    = 8,
  parameter int N    = 8,
  parameter int T    = 16,
  parameter int P    = 2,
  parameter int RELU = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          input_valid,
  output logic                          input_ready,
  input  logic [T-1:0]                  input_data,
  output logic                          output_valid,
  input  logic                          output_ready,
  output logic [T-1:0]                  output_data,
  output logic [addr_width(M,P,N)-1:0]  addr_w,
  input  logic [P*T-1:0]                w_data
);

  localparam int G  = M / P;
  localparam int AW = addr_width(M, P, N);
  localparam int XW = cnt_width(N);
  localparam int CW = cnt_width(N + 1);
  localparam int LW = cnt_width(P);
  localparam int GW = cnt_width(G);

  localparam logic [XW-1:0] K_LAST = XW'(N - 1);
  localparam logic [CW-1:0] C_LAST = CW'(N);
  localparam logic [LW-1:0] L_LAST = LW'(P - 1);
  localparam logic [GW-1:0] G_LAST = GW'(G - 1);

  if (M % P != 0) begin : g_bad_p
    $error("fc_par_layer: M must be a multiple of P");
  end

  fc_state_t           state_r;
  fc_state_t           state_next_s;
  logic [XW-1:0]       k_r;
  logic [CW-1:0]       c_r;
  logic [LW-1:0]       lane_r;
  logic [GW-1:0]       g_r;
  logic                accept_s;
  logic                out_fire_s;
  logic                clr_s;
  logic                en_s;
  logic                cap_s;
  logic [XW-1:0]       mem_addr_s;
  logic [T-1:0]        xbuf_r [N];
  logic [T-1:0]        x_q_r;
  logic signed [T-1:0] res_s [P];

  assign input_ready  = (state_r == S_LOAD);
  assign output_valid = (state_r == S_OUT);
  assign accept_s     = input_valid && (state_r == S_LOAD);
  assign out_fire_s   = output_valid && output_ready;

  // Clear on any entry into S_MAC; cycle 0 only issues reads, cycles 1..N add.
  assign clr_s = (state_next_s == S_MAC) && (state_r != S_MAC);
  assign en_s  = (state_r == S_MAC) && (c_r != '0);
  assign cap_s = (state_r == S_MAC) && (c_r == C_LAST);

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_LOAD: begin
        if (accept_s && (k_r == K_LAST)) begin
          state_next_s = S_MAC;
        end else begin
          state_next_s = S_LOAD;
        end
      end
      S_MAC: begin
        if (c_r == C_LAST) begin
          state_next_s = S_OUT;
        end else begin
          state_next_s = S_MAC;
        end
      end
      S_OUT: begin
        if (out_fire_s && (lane_r == L_LAST)) begin
          if (g_r == G_LAST) begin
            state_next_s = S_LOAD;
          end else begin
            state_next_s = S_MAC;
          end
        end else begin
          state_next_s = S_OUT;
        end
      end
      default: state_next_s = S_LOAD;
    endcase
  end

  // State register and the k / c / lane / g counters, each wrapping at its end.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_LOAD;
      k_r     <= '0;
      c_r     <= '0;
      lane_r  <= '0;
      g_r     <= '0;
    end else begin
      state_r <= state_next_s;
      case (state_r)
        S_LOAD: begin
          if (accept_s) begin
            k_r <= (k_r == K_LAST) ? '0 : k_r + 1'b1;
          end else begin
            k_r <= k_r;
          end
        end
        S_MAC: begin
          c_r <= (c_r == C_LAST) ? '0 : c_r + 1'b1;
        end
        S_OUT: begin
          if (out_fire_s) begin
            if (lane_r == L_LAST) begin
              lane_r <= '0;
              g_r    <= (g_r == G_LAST) ? '0 : g_r + 1'b1;
            end else begin
              lane_r <= lane_r + 1'b1;
            end
          end else begin
            lane_r <= lane_r;
          end
        end
        default: begin
          k_r <= '0;
        end
      endcase
    end
  end

  // Single x-buffer port: write index k while loading, read index c while
  // accumulating. The terminal MAC cycle reads nothing useful.
  always_comb begin
    if (state_r == S_LOAD) begin
      mem_addr_s = k_r;
    end else if (c_r != C_LAST) begin
      mem_addr_s = XW'(c_r);
    end else begin
      mem_addr_s = '0;
    end
  end

  // x buffer with registered read; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      xbuf_r[mem_addr_s] <= input_data;
    end
    x_q_r <= xbuf_r[mem_addr_s];
  end

  // Weight address follows the x read index so both arrive together next cycle.
  always_comb begin
    if ((state_r == S_MAC) && (c_r != C_LAST)) begin
      addr_w = (AW'(g_r) * AW'(N)) + AW'(c_r);
    end else begin
      addr_w = '0;
    end
  end

  for (genvar p = 0; p < P; p++) begin : g_lane
    fc_mac_lane #(
      .N    (N),
      .T    (T),
      .RELU (RELU)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .clr   (clr_s),
      .en    (en_s),
      .cap   (cap_s),
      .w     ($signed(w_data[p*T +: T])),
      .x     ($signed(x_q_r)),
      .res   (res_s[p])
    );
  end

  // Present the held lane results in lane order while draining.
  always_comb begin
    if (state_r == S_OUT) begin
      output_data = res_s[lane_r];
    end else begin
      output_data = '0;
    end
  end

endmodule

// File: tb/tb_fc_par_layer.sv
// -----------------------------------------------------------------------------
// tb_fc_par_layer
// Scoreboard bench: two instances (RELU=0 and RELU=1) share stimulus; each
// has its own weight ROM model and expected-result queue.
// -----------------------------------------------------------------------------
module tb_fc_par_layer;

  localparam int M  = 4;
  localparam int N  = 4;
  localparam int T  = 8;
  localparam int P  = 2;
  localparam int AW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          input_valid;
  logic [T-1:0]  input_data;
  logic          output_ready;
  logic          input_ready0, input_ready1;
  logic          output_valid0, output_valid1;
  logic [T-1:0]  output_data0, output_data1;
  logic [AW-1:0] addr_w0, addr_w1;
  logic [P*T-1:0] w_data0, w_data1;

  logic signed [T-1:0] wmat [M][N];
  int q0[$];
  int q1[$];
  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int out_cnt  = 0;

  fc_par_layer #(.M(M), .N(N), .T(T), .P(P), .RELU(0)) dut0 (
    .clk(clk), .reset(reset), .input_valid(input_valid), .input_ready(input_ready0),
    .input_data(input_data), .output_valid(output_valid0), .output_ready(output_ready),
    .output_data(output_data0), .addr_w(addr_w0), .w_data(w_data0)
  );

  fc_par_layer #(.M(M), .N(N), .T(T), .P(P), .RELU(1)) dut1 (
    .clk(clk), .reset(reset), .input_valid(input_valid), .input_ready(input_ready1),
    .input_data(input_data), .output_valid(output_valid1), .output_ready(output_ready),
    .output_data(output_data1), .addr_w(addr_w1), .w_data(w_data1)
  );

  task automatic check_val(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [P*T-1:0] rom_word(input logic [AW-1:0] a);
    int g;
    int k;
    logic [P*T-1:0] r;
    g = int'(a) / N;
    k = int'(a) % N;
    for (int p = 0; p < P; p++) r[p*T +: T] = wmat[g*P+p][k];
    return r;
  endfunction

  // Registered one-cycle weight ROMs.
  always @(posedge clk) begin
    w_data0 <= rom_word(addr_w0);
    w_data1 <= rom_word(addr_w1);
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, latency and busy checks, sampled on the falling edge.
  logic prev_ov;
  int   acc_in_vec;
  int   last_acc_cyc;
  bit   lat_armed;
  always @(negedge clk) begin
    if (!reset) begin
      prev_ov    = 1'b0;
      acc_in_vec = 0;
      lat_armed  = 1'b0;
    end else begin
      if (input_valid && input_ready0) begin
        acc_in_vec++;
        if (acc_in_vec == N) begin
          acc_in_vec   = 0;
          last_acc_cyc = cyc;
          lat_armed    = 1'b1;
        end
      end
      if (output_valid0 && !prev_ov && lat_armed) begin
        check_val("latency", cyc - last_acc_cyc, N + 2);
        lat_armed = 1'b0;
      end
      prev_ov = output_valid0;
      if (output_valid0) check_val("ready_while_busy", int'(input_ready0), 0);
      if (output_valid0) begin
        if (q0.size() == 0) check_val("unexpected_y0", 1, 0);
        else if (output_ready) check_val("y_relu0", int'($signed(output_data0)), q0.pop_front());
        else check_val("stall_hold0", int'($signed(output_data0)), q0[0]);
        if (output_ready) out_cnt++;
      end
      if (output_valid1) begin
        if (q1.size() == 0) check_val("unexpected_y1", 1, 0);
        else if (output_ready) check_val("y_relu1", int'($signed(output_data1)), q1.pop_front());
        else check_val("stall_hold1", int'($signed(output_data1)), q1[0]);
      end
    end
  end

  task automatic push_expected(input int x[N]);
    int s;
    for (int i = 0; i < M; i++) begin
      s = 0;
      for (int k = 0; k < N; k++) s += int'(wmat[i][k]) * x[k];
      if (s > 127) s = 127;
      else if (s < -128) s = -128;
      q0.push_back(s);
      q1.push_back((s < 0) ? 0 : s);
    end
  endtask

  task automatic send_vector(input int x[N], input bit hold_valid);
    int t;
    for (int i = 0; i < N; i++) begin
      input_valid = 1'b1;
      input_data  = T'(x[i]);
      t = 0;
      while (!input_ready0 && t < 300) begin
        @(posedge clk); #1;
        t++;
      end
      if (t >= 300) begin
        check_val("input_timeout", t, 0);
        input_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    if (!hold_valid) input_valid = 1'b0;
  endtask

  task automatic run_until_done(input bit rand_ready);
    int t;
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 400) begin
      if (rand_ready) output_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      t++;
    end
    output_ready = 1'b1;
    check_val("drain_q0", q0.size(), 0);
    check_val("drain_q1", q1.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic set_identity();
    for (int i = 0; i < M; i++)
      for (int k = 0; k < N; k++) wmat[i][k] = (i == k) ? 8'sd1 : 8'sd0;
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < M; i++)
      for (int k = 0; k < N; k++) wmat[i][k] = T'(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int base;
    int v1[N];
    int v2[N];
    int w;
    reset        = 1'b0;
    input_valid  = 1'b0;
    input_data   = '0;
    output_ready = 1'b1;
    set_identity();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_output_valid", int'(output_valid0), 0);
    check_val("rst_input_ready", int'(input_ready0), 1);
    check_val("rst_output_data", int'(output_data0), 0);
    check_val("rst_addr_w", int'(addr_w0), 0);
    check_val("rst_output_valid1", int'(output_valid1), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Identity weights
    push_expected('{1, 2, 3, 4});
    send_vector('{1, 2, 3, 4}, 1'b0);
    run_until_done(1'b0);

    // Saturate high
    set_all(127);
    push_expected('{127, 127, 127, 127});
    send_vector('{127, 127, 127, 127}, 1'b0);
    run_until_done(1'b0);

    // Saturate low / ReLU clamp
    push_expected('{-128, -128, -128, -128});
    send_vector('{-128, -128, -128, -128}, 1'b0);
    run_until_done(1'b0);

    // Five-cycle stall at the first output
    set_identity();
    output_ready = 1'b0;
    push_expected('{-3, 7, -100, 50});
    send_vector('{-3, 7, -100, 50}, 1'b0);
    t = 0;
    while (!output_valid0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check_val("stall_wait_valid", int'(output_valid0), 1);
    repeat (5) @(posedge clk);
    #1;
    output_ready = 1'b1;
    run_until_done(1'b0);

    // Reset while group 1 accumulates
    base = out_cnt;
    push_expected('{5, 6, 7, 8});
    send_vector('{5, 6, 7, 8}, 1'b0);
    t = 0;
    while (out_cnt < base + 2 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check_val("group0_delivered", out_cnt - base, 2);
    @(posedge clk); #1;
    check_val("addr_group1_c1", int'(addr_w0), 5);
    reset = 1'b0;
    #1;
    check_val("midrst_output_valid", int'(output_valid0), 0);
    check_val("midrst_input_ready", int'(input_ready0), 1);
    check_val("midrst_addr_w", int'(addr_w0), 0);
    q0.delete();
    q1.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    push_expected('{1, 0, 0, 0});
    send_vector('{1, 0, 0, 0}, 1'b0);
    run_until_done(1'b0);

    // Back-to-back vectors with input_valid held high, random weights
    for (int i = 0; i < M; i++)
      for (int k = 0; k < N; k++) begin
        w = int'($urandom_range(0, 255));
        wmat[i][k] = w[7:0];
      end
    for (int k = 0; k < N; k++) begin
      v1[k] = int'($urandom_range(0, 255)) - 128;
      v2[k] = int'($urandom_range(0, 60)) - 30;
    end
    push_expected(v1);
    push_expected(v2);
    send_vector(v1, 1'b1);
    send_vector(v2, 1'b0);
    run_until_done(1'b0);

    // Random backpressure
    for (int k = 0; k < N; k++) v1[k] = int'($urandom_range(0, 40)) - 20;
    push_expected(v1);
    send_vector(v1, 1'b0);
    run_until_done(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
